// File: rtl/div_pkg.sv
// Shared types for the iterative divider: operation codes, FSM states and
// small decoders that classify an operation by width, signedness and result kind.
package div_pkg;

   localparam int WORD_BITS = 32;

   typedef enum logic [2:0] {
      OP_DIV   = 3'd0,
      OP_DIVU  = 3'd1,
      OP_REM   = 3'd2,
      OP_REMU  = 3'd3,
      OP_DIVW  = 3'd4,
      OP_DIVUW = 3'd5,
      OP_REMW  = 3'd6,
      OP_REMUW = 3'd7
   } div_op_t;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_CALC = 3'd2,
      S_FIX  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   function automatic logic is_word(input div_op_t op);
      return op inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
   endfunction

   function automatic logic is_signed(input div_op_t op);
      return op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
   endfunction

   function automatic logic is_rem(input div_op_t op);
      return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_step #(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic [XLEN-1:0] quo_next
);

   // The shifted remainder needs one extra bit because an unsigned divisor may use all XLEN bits.
   logic [XLEN:0] shifted;

   always_comb begin
      shifted = {rem, quo[XLEN-1]};
      if (shifted >= {1'b0, divisor}) begin
         rem_next = shifted[XLEN-1:0] - divisor;
         quo_next = {quo[XLEN-2:0], 1'b1};
      end else begin
         rem_next = shifted[XLEN-1:0];
         quo_next = {quo[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_seq_unit.sv
// Sequential radix-2 divider for RV64M DIV/DIVU/REM/REMU and their W forms,
// one operation in flight, valid/ready on both the request and result sides.
module div_seq_unit
   import div_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  div_op_t         op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] WORD_MIN = {{(XLEN-WORD_BITS+1){1'b1}}, {(WORD_BITS-1){1'b0}}};

   state_t          state, state_next;
   div_op_t         op_q;
   logic [XLEN-1:0] a_q, b_q, rem_q, quo_q, div_q, result_q;
   logic [CW-1:0]   cnt_q;
   logic            neg_quo_q, neg_rem_q;

   logic            word, sgn, rem_op;
   logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b;
   logic            s1, s2, div_zero, overflow, special;
   logic [XLEN-1:0] special_raw, special_val;
   logic [XLEN-1:0] quo_signed, rem_signed, sel, fix_val;
   logic [XLEN-1:0] rem_next, quo_next;

   function automatic logic [XLEN-1:0] sext_word(input logic [WORD_BITS-1:0] v);
      return {{(XLEN-WORD_BITS){v[WORD_BITS-1]}}, v};
   endfunction

   assign word   = is_word(op_q);
   assign sgn    = is_signed(op_q);
   assign rem_op = is_rem(op_q);

   // Operand preparation: widen W operands, then reduce signed operands to magnitudes.
   always_comb begin
      a_ext = a_q;
      b_ext = b_q;
      if (word) begin
         a_ext = sgn ? sext_word(a_q[WORD_BITS-1:0]) : {{(XLEN-WORD_BITS){1'b0}}, a_q[WORD_BITS-1:0]};
         b_ext = sgn ? sext_word(b_q[WORD_BITS-1:0]) : {{(XLEN-WORD_BITS){1'b0}}, b_q[WORD_BITS-1:0]};
      end
      s1          = sgn & a_ext[XLEN-1];
      s2          = sgn & b_ext[XLEN-1];
      mag_a       = s1 ? -a_ext : a_ext;
      mag_b       = s2 ? -b_ext : b_ext;
      div_zero    = (b_ext == '0);
      overflow    = sgn && (b_ext == '1) && (a_ext == (word ? WORD_MIN : MIN_VAL));
      special     = div_zero || overflow;
      special_raw = div_zero ? (rem_op ? a_ext : '1) : (rem_op ? '0 : a_ext);
      special_val = word ? sext_word(special_raw[WORD_BITS-1:0]) : special_raw;
   end

   // Final sign fix-up and quotient/remainder selection.
   always_comb begin
      quo_signed = neg_quo_q ? -quo_q : quo_q;
      rem_signed = neg_rem_q ? -rem_q : rem_q;
      sel        = rem_op ? rem_signed : quo_signed;
      fix_val    = word ? sext_word(sel[WORD_BITS-1:0]) : sel;
   end

   div_step #(.XLEN(XLEN)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (div_q),
      .rem_next (rem_next),
      .quo_next (quo_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (in_valid) state_next = S_PREP;
            S_PREP: state_next = special ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == '0) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
         endcase
      end
   end

   // Datapath registers; a flush freezes everything so the last result stays visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q      <= OP_DIV;
         a_q       <= '0;
         b_q       <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         div_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else if (!flush) begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_q <= op;
                  a_q  <= rs1;
                  b_q  <= rs2;
               end
            end
            S_PREP: begin
               if (special) begin
                  result_q <= special_val;
               end else begin
                  rem_q     <= '0;
                  quo_q     <= word ? (mag_a << (XLEN - WORD_BITS)) : mag_a;
                  div_q     <= mag_b;
                  cnt_q     <= word ? CW'(WORD_BITS - 1) : CW'(XLEN - 1);
                  neg_quo_q <= s1 ^ s2;
                  neg_rem_q <= s1;
               end
            end
            S_CALC: begin
               rem_q <= rem_next;
               quo_q <= quo_next;
               cnt_q <= cnt_q - CW'(1);
            end
            S_FIX: result_q <= fix_val;
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign result    = result_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Self-checking bench for div_seq_unit: directed RISC-V corner cases, flush,
// backpressure, random back-to-back ops and reset mid-operation against a scoreboard.
module tb_div_seq_unit;
   import div_pkg::*;

   localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   div_op_t     op;
   logic [63:0] rs1, rs2, result;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] exp_q[$];
   logic [63:0] last_result;

   always #5 clk = ~clk;

   div_seq_unit #(.XLEN(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .rs1       (rs1),
      .rs2       (rs2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [63:0] model(input div_op_t o, input logic [63:0] a, input logic [63:0] b);
      logic [31:0] a32, b32, r32;
      logic [63:0] r;
      a32 = a[31:0];
      b32 = b[31:0];
      r   = '0;
      r32 = '0;
      case (o)
         OP_DIV:   if (b == 0) r = ONES; else if (a == MIN64 && b == ONES) r = MIN64; else r = $signed(a) / $signed(b);
         OP_DIVU:  if (b == 0) r = ONES; else r = a / b;
         OP_REM:   if (b == 0) r = a; else if (a == MIN64 && b == ONES) r = '0; else r = $signed(a) % $signed(b);
         OP_REMU:  if (b == 0) r = a; else r = a % b;
         OP_DIVW:  if (b32 == 0) r32 = '1; else if (a32 == 32'h8000_0000 && b32 == '1) r32 = 32'h8000_0000; else r32 = $signed(a32) / $signed(b32);
         OP_DIVUW: if (b32 == 0) r32 = '1; else r32 = a32 / b32;
         OP_REMW:  if (b32 == 0) r32 = a32; else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0; else r32 = $signed(a32) % $signed(b32);
         OP_REMUW: if (b32 == 0) r32 = a32; else r32 = a32 % b32;
         default:  r = '0;
      endcase
      if (o inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW}) r = {{32{r32[31]}}, r32};
      return r;
   endfunction

   function automatic int model_latency(input div_op_t o, input logic [63:0] a, input logic [63:0] b);
      logic w, s;
      w = o inside {OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
      s = o inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
      if (w) return (b[31:0] == 0 || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) ? 2 : 35;
      return (b == 0 || (s && a == MIN64 && b == ONES)) ? 2 : 67;
   endfunction

   // Drive one request at a negedge, push its expected result, return at the negedge after acceptance.
   task automatic send_op(input div_op_t o, input logic [63:0] a, input logic [63:0] b);
      int waited = 0;
      while (!in_ready && waited < 200) begin
         @(posedge clk);
         @(negedge clk);
         waited++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("[TB] FAIL send_ready: in_ready=%0b required 1", in_ready);
      end
      op       = o;
      rs1      = a;
      rs2      = b;
      in_valid = 1'b1;
      exp_q.push_back(model(o, a, b));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Latency counts clock edges from the accept edge (1) up to the edge that raises out_valid.
   task automatic wait_result(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic take_result();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'h0) begin
         errors++;
         $display("[TB] FAIL reset_state: in_ready=%0b out_valid=%0b result=%h required 1 0 0", in_ready, out_valid, result);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_divide();
      div_op_t     t_op [9] = '{OP_DIV, OP_REM, OP_REMU, OP_DIVU, OP_REM, OP_DIV, OP_REM, OP_DIVW, OP_DIVUW};
      logic [63:0] t_a  [9] = '{64'hFFFF_FFFF_FFFF_FFEC, 64'hFFFF_FFFF_FFFF_FFEC, 64'd20, 64'd5, 64'd5,
                                MIN64, MIN64, 64'h1_8000_0000, 64'hFFFF_FFFF};
      logic [63:0] t_b  [9] = '{64'd3, 64'd3, 64'd3, 64'd0, 64'd0, ONES, ONES, ONES, 64'd2};
      logic [63:0] t_res[9] = '{64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, ONES, 64'd5,
                                MIN64, 64'd0, 64'hFFFF_FFFF_8000_0000, 64'h7FFF_FFFF};
      int          t_lat[9] = '{67, 67, 67, 2, 2, 2, 2, 2, 35};
      int          lat;
      logic [63:0] exp;
      for (int i = 0; i < 9; i++) begin
         send_op(t_op[i], t_a[i], t_b[i]);
         wait_result(lat);
         exp = exp_q.pop_front();
         checks++;
         if (result !== exp || !out_valid) begin
            errors++;
            $display("[TB] FAIL divide_sb[%0d]: result=%h valid=%0b required %h", i, result, out_valid, exp);
         end
         checks++;
         if (result !== t_res[i]) begin
            errors++;
            $display("[TB] FAIL divide_const[%0d]: result=%h required %h", i, result, t_res[i]);
         end
         checks++;
         if (lat != t_lat[i]) begin
            errors++;
            $display("[TB] FAIL divide_latency[%0d]: latency=%0d required %0d", i, lat, t_lat[i]);
         end
         last_result = t_res[i];
         take_result();
      end
   endtask

   task automatic test_flush();
      int          seen = 0;
      int          lat;
      logic [63:0] exp;
      send_op(OP_DIV, 64'd1000, 64'd7);
      repeat (11) begin
         @(posedge clk);
         @(negedge clk);
      end
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      void'(exp_q.pop_back());
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== last_result) begin
         errors++;
         $display("[TB] FAIL flush_calc: in_ready=%0b out_valid=%0b result=%h required 1 0 %h", in_ready, out_valid, result, last_result);
      end
      repeat (80) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("[TB] FAIL flush_no_valid: out_valid cycles=%0d required 0", seen);
      end
      op       = OP_DIVU;
      rs1      = 64'd9;
      rs2      = 64'd3;
      in_valid = 1'b1;
      flush    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_beats_accept: in_ready=%0b required 1", in_ready);
      end
      send_op(OP_DIVU, 64'd100, 64'd7);
      wait_result(lat);
      exp = exp_q.pop_front();
      checks++;
      if (result !== exp || result !== 64'd14 || lat != 67) begin
         errors++;
         $display("[TB] FAIL flush_next_op: result=%h latency=%0d required %h 67", result, lat, exp);
      end
      out_ready = 1'b1;
      flush     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      flush     = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 64'd14) begin
         errors++;
         $display("[TB] FAIL flush_done: out_valid=%0b in_ready=%0b result=%h required 0 1 %h", out_valid, in_ready, result, 64'd14);
      end
      last_result = 64'd14;
   endtask

   task automatic test_backpressure();
      int          lat;
      int          bad = 0;
      logic [63:0] exp;
      send_op(OP_REMW, 64'h0000_0001_FFFF_FF9C, 64'd7);
      wait_result(lat);
      exp = exp_q.pop_front();
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         if (!out_valid || result !== exp) bad++;
      end
      checks++;
      if (bad != 0 || exp !== 64'hFFFF_FFFF_FFFF_FFFE) begin
         errors++;
         $display("[TB] FAIL backpressure_hold: unstable cycles=%0d result=%h required %h", bad, result, 64'hFFFF_FFFF_FFFF_FFFE);
      end
      take_result();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL backpressure_release: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
      end
      last_result = exp;
   endtask

   function automatic logic [63:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 64'($urandom_range(0, 1000));
         1: return {$urandom, $urandom};
         2: return 64'd0;
         3: return MIN64;
         4: return ONES;
         default: return {32'($urandom_range(0, 3)), $urandom};
      endcase
   endfunction

   task automatic test_back_to_back();
      div_op_t     o;
      logic [63:0] a, b, exp;
      int          lat;
      int          want_lat;
      for (int i = 0; i < 30; i++) begin
         o        = div_op_t'($urandom_range(0, 7));
         a        = rand_operand();
         b        = rand_operand();
         want_lat = model_latency(o, a, b);
         send_op(o, a, b);
         wait_result(lat);
         exp = exp_q.pop_front();
         checks++;
         if (result !== exp || lat != want_lat) begin
            errors++;
            $display("[TB] FAIL b2b[%0d] op=%0d a=%h b=%h: result=%h latency=%0d required %h %0d", i, o, a, b, result, lat, exp, want_lat);
         end
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            @(negedge clk);
         end
         take_result();
      end
   endtask

   task automatic test_reset_mid_op();
      int          lat;
      logic [63:0] exp;
      send_op(OP_DIVU, 64'd1000, 64'd3);
      repeat (20) begin
         @(posedge clk);
         @(negedge clk);
      end
      void'(exp_q.pop_back());
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'h0) begin
         errors++;
         $display("[TB] FAIL reset_mid_op: in_ready=%0b out_valid=%0b result=%h required 1 0 0", in_ready, out_valid, result);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send_op(OP_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
      wait_result(lat);
      exp = exp_q.pop_front();
      checks++;
      if (result !== exp || lat != 67) begin
         errors++;
         $display("[TB] FAIL reset_recover: result=%h latency=%0d required %h 67", result, lat, exp);
      end
      take_result();
   endtask

   initial begin
      rst         = 1'b1;
      flush       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      op          = OP_DIV;
      rs1         = '0;
      rs2         = '0;
      last_result = '0;
      test_reset();
      test_divide();
      test_flush();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
